// File: rtl/riscv_mem_pkg.sv
// Shared memory-op definitions: RV32I load/store funct3 encodings and LSU state type.
// Decode also uses this package.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so they accept a narrower funct3 set.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else          ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: selects the addressed byte/halfword from the memory word
// and sign- or zero-extends it to XLEN.
module lsu_load_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   result_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result_o = rdata_i;
      F3_LBU:  result_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one req/ack data-memory transaction per
// EX/MEM memory op, stalls the pipeline meanwhile and formats load data for MEM/WB.
//
// state | meaning
// IDLE  | waiting for a valid, non-faulting memory op; accept cycle stalls combinationally
// REQ   | request held on dmem port with latched we/addr/be/wdata until ack
// DONE  | one cycle, stall released so the pipeline advances past the completed op
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   st_dai,
  output logic              stall_o,
  output logic [XLEN-1:0]   ld_dao,
  output logic              fault_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);

  lsu_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   ld_q;

  logic              mem_op;
  logic              illegal;
  logic              misalign;
  logic              fault_c;
  logic              in_idle;
  logic              start;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ld_fmt;

  assign mem_op   = valid_i & (mem_rd_i | mem_wr_i);
  // A op with both rd and wr set is a store, so store legality applies.
  assign illegal  = ~f3_legal(mem_wr_i, funct3_i);
  assign misalign = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  assign fault_c  = illegal | misalign;
  assign in_idle  = (state_q == IDLE);
  assign start    = in_idle & mem_op & ~fault_c;

  assign fault_o  = ~rst_i & in_idle & mem_op & fault_c;
  assign stall_o  = ~rst_i & (start | (state_q == REQ));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = st_dai;
    case (funct3_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{st_dai[7:0]}};
      end
      2'b01: begin
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_dai[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = st_dai;
      end
    endcase
  end

  // Formatting uses the offset/size latched at accept; rdata is only valid with ack.
  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem_rdata_i),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (ld_fmt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      ld_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= mem_wr_i;
            addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
          end
        end
        REQ: begin
          if (dmem_ack_i) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) ld_q <= ld_fmt;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ld_dao       = ld_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a per-cycle expectation schedule built from
// arithmetic rules for size, lanes and extension, checked every negedge.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_rd_i, mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, st_dai;
  logic        stall_o, fault_o;
  logic [31:0] ld_dao;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .st_dai       (st_dai),
    .stall_o      (stall_o),
    .ld_dao       (ld_dao),
    .fault_o      (fault_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_fault, exp_req, exp_we;
  logic        exp_chk_bus, exp_chk_wd;
  logic [31:0] exp_addr, exp_wdata, model_ld;
  logic [3:0]  exp_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference rules written as plain arithmetic on access size.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = wr ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!legal) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    for (int k = 0; k < m_size(f3); k++) m[int'(a[1:0]) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] st);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = st[8*(i % m_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [63:0] v, mask;
    int bits;
    bits = 8 * m_size(f3);
    v    = {32'd0, rd >> (8 * a[1:0])};
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
      chk("fault_o", {31'd0, fault_o}, {31'd0, exp_fault});
      chk("dmem_req_o", {31'd0, dmem_req_o}, {31'd0, exp_req});
      chk("ld_dao", ld_dao, model_ld);
      if (exp_chk_bus) begin
        chk("dmem_we_o", {31'd0, dmem_we_o}, {31'd0, exp_we});
        chk("dmem_addr_o", dmem_addr_o, exp_addr);
        chk("dmem_be_o", {28'd0, dmem_be_o}, {28'd0, exp_be});
        if (exp_chk_wd) chk("dmem_wdata_o", dmem_wdata_o, exp_wdata);
      end
      if (stall_o === 1'b1) stall_cnt++;
      if (dmem_req_o === 1'b1) req_cnt++;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_exp();
    exp_stall = 0; exp_fault = 0; exp_req = 0; exp_chk_bus = 0; exp_chk_wd = 0;
  endtask

  // One memory op with ack in the n-th REQ cycle; lit_* are hand-computed values
  // (lit_stall==0 skips the latency literal).
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] st, input logic [31:0] rdata,
                       input int n, input bit lit_en, input logic [31:0] lit_ld,
                       input logic [3:0] lit_be, input logic [31:0] lit_wd, input int lit_stall);
    bit flt;
    int s0, r0;
    step();
    valid_i = 1; mem_rd_i = rd; mem_wr_i = wr; funct3_i = f3; addr_i = a; st_dai = st;
    dmem_ack_i = 0;
    flt = m_fault(wr, f3, a);
    idle_exp();
    exp_fault = flt;
    exp_stall = !flt;
    s0 = stall_cnt; r0 = req_cnt;
    if (flt) begin
      step();
      valid_i = 0;
      idle_exp();
      step();
      return;
    end
    for (int i = 1; i <= n; i++) begin
      step();
      exp_req = 1; exp_stall = 1; exp_fault = 0;
      exp_chk_bus = 1; exp_chk_wd = wr;
      exp_we = wr; exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a); exp_wdata = m_wd(f3, st);
      dmem_ack_i   = (i == n);
      dmem_rdata_i = (i == n) ? rdata : $urandom;
      if (lit_en && i == 1) begin
        chk("lit_be", {28'd0, dmem_be_o}, {28'd0, lit_be});
        if (wr) chk("lit_wdata", dmem_wdata_o, lit_wd);
      end
    end
    step();
    dmem_ack_i = 0; dmem_rdata_i = $urandom;
    idle_exp();
    if (!wr) model_ld = m_ld(f3, a, rdata);
    if (lit_en && !wr) chk("lit_ld_dao", ld_dao, lit_ld);
    step();
    valid_i = 0;
    idle_exp();
    if (lit_stall > 0) begin
      chk("lit_stall_cycles", 32'(stall_cnt - s0), 32'(lit_stall));
      chk("lit_req_cycles", 32'(req_cnt - r0), 32'(lit_stall - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; valid_i = 0; mem_rd_i = 0; mem_wr_i = 0; funct3_i = 0;
    addr_i = 0; st_dai = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    model_ld = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    idle_exp();
    step(); step();
    exp_chk_bus = 1; exp_chk_wd = 1;
    chk_en = 1;
    step();
    rst_i = 0;
    step();
    idle_exp();

    // LW 0x100, ack on 3rd REQ cycle
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 4'b1111, 32'h0, 4);
    // load formatting
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 1, 32'hFFFFFF80, 4'b1000, 32'h0, 0);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2, 1, 32'h00000080, 4'b1000, 32'h0, 0);
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 1, 1, 32'hFFFF8012, 4'b1100, 32'h0, 0);
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 2, 1, 32'h00008012, 4'b1100, 32'h0, 0);
    do_op(1, 0, 3'b000, 32'h100, 32'h0, 32'h801234D6, 1, 1, 32'hFFFFFFD6, 4'b0001, 32'h0, 0);
    do_op(1, 0, 3'b001, 32'h100, 32'h0, 32'h12347FFF, 1, 1, 32'h00007FFF, 4'b0011, 32'h0, 0);
    // stores; ld_dao must hold across them
    do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 1, 32'h0, 4'b1100, 32'hABCDABCD, 3);
    do_op(0, 1, 3'b000, 32'h201, 32'h1234ABCD, 32'h0, 1, 1, 32'h0, 4'b0010, 32'hCDCDCDCD, 0);
    do_op(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1, 1, 32'h0, 4'b1111, 32'hCAFEF00D, 0);
    do_op(1, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, 1, 32'h0, 4'b1000, 32'hA5A5A5A5, 0);
    // faults
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0);
    do_op(0, 1, 3'b001, 32'h101, 32'h5555, 32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0);
    do_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0);
    do_op(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0);
    do_op(1, 0, 3'b101, 32'h103, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0);
    // zero-wait ack: stall exactly 2, no re-request
    do_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 4'b1111, 32'h0, 2);

    // stray ack while idle is ignored
    step();
    dmem_ack_i = 1; dmem_rdata_i = 32'h11111111;
    step();
    dmem_ack_i = 0;

    // reset during REQ
    step();
    valid_i = 1; mem_rd_i = 1; mem_wr_i = 0; funct3_i = 3'b010; addr_i = 32'h404; st_dai = 32'h77777777;
    idle_exp(); exp_stall = 1;
    step();
    exp_req = 1; exp_stall = 1; exp_chk_bus = 1; exp_chk_wd = 0;
    exp_we = 0; exp_addr = 32'h404; exp_be = 4'b1111;
    step();
    rst_i = 1;
    exp_stall = 0;
    step();
    rst_i = 0; valid_i = 0;
    model_ld = 0;
    idle_exp(); exp_chk_bus = 1; exp_chk_wd = 1;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    step();
    dmem_ack_i = 1; dmem_rdata_i = 32'h99999999;
    step();
    dmem_ack_i = 0;
    step();
    step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
